spi_bus_arbiter: RTL

//  Shares one physical SPI slave bus between NUM_REQ SPI masters, each typically
//  a DPI-driven master on its own socket port, all clocked by sys_clk.

---
 rtl/spi_arb_pkg.sv | 20 ++
 rtl/spi_rr_pick.sv | 29 ++
 rtl/spi_bus_arbiter.sv | 121 ++++++++++++
 3 files changed

// File: rtl/spi_arb_pkg.sv
// rtl/spi_arb_pkg.sv - shared state type, bus idle levels and width helper for the SPI bus arbiter
package spi_arb_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_GRANT,
      ST_DRAIN
   } arb_state_t;

   localparam logic SPI_CS_IDLE   = 1'b1;
   localparam logic SPI_MOSI_IDLE = 1'b0;

   // Counter widths must never collapse to zero bits when the count limit is 0.
   function automatic int clog2_min1(input int n);
      int r;
      r = $clog2(n);
      return (r < 1) ? 1 : r;
   endfunction

endpackage

// File: rtl/spi_rr_pick.sv
// rtl/spi_rr_pick.sv - combinational round-robin picker, searches upward from last+1 with wrap
module spi_rr_pick
   import spi_arb_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int IW      = clog2_min1(NUM_REQ)
)(
   input  logic [NUM_REQ-1:0] eligible,
   input  logic [IW-1:0]      last,
   output logic               valid,
   output logic [IW-1:0]      winner
);

   logic [IW-1:0] idx;

   always_comb begin
      valid  = 1'b0;
      winner = '0;
      idx    = '0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         idx = IW'((int'(last) + k) % NUM_REQ);
         if (!valid && eligible[idx]) begin
            valid  = 1'b1;
            winner = idx;
         end
      end
   end

endmodule

// File: rtl/spi_bus_arbiter.sv
// rtl/spi_bus_arbiter.sv - shares one SPI slave bus among NUM_REQ masters with round-robin grants
module spi_bus_arbiter
   import spi_arb_pkg::*;
#(
   parameter int   NUM_REQ        = 4,
   parameter int   GAP_CYCLES     = 2,
   parameter int   TIMEOUT_CYCLES = 0,
   parameter logic CPOL           = 1'b1
)(
   input  logic                       sys_clk,
   input  logic                       sys_rst,
   input  logic [NUM_REQ-1:0]         req_i,
   output logic [NUM_REQ-1:0]         gnt_o,
   input  logic [NUM_REQ-1:0]         m_cs_i,
   input  logic [NUM_REQ-1:0]         m_clk_i,
   input  logic [NUM_REQ-1:0]         m_mosi_i,
   output logic [NUM_REQ-1:0]         m_miso_o,
   output logic                       spi_cs_o,
   output logic                       spi_clk_o,
   output logic                       spi_mosi_o,
   input  logic                       spi_miso_i,
   output logic [$clog2(NUM_REQ)-1:0] owner_o,
   output logic                       busy_o,
   output logic                       timeout_o
);

   localparam int IW   = $clog2(NUM_REQ);
   localparam int TW   = clog2_min1(TIMEOUT_CYCLES + 1);
   localparam int GW   = clog2_min1(GAP_CYCLES + 1);
   localparam int TLIM = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;

   arb_state_t         state;
   logic [NUM_REQ-1:0] mask;
   logic [NUM_REQ-1:0] mask_next;
   logic [NUM_REQ-1:0] eligible;
   logic [IW-1:0]      last;
   logic [TW-1:0]      tcnt;
   logic [GW-1:0]      gcnt;
   logic               pick_valid;
   logic [IW-1:0]      pick_idx;
   logic               to_hit;
   logic               owner_req;

   assign eligible  = req_i & ~mask;
   assign owner_req = req_i[owner_o];
   assign to_hit    = (TIMEOUT_CYCLES != 0) && (tcnt == TW'(TLIM));
   assign busy_o    = (state != ST_IDLE);
   assign m_miso_o  = gnt_o & {NUM_REQ{spi_miso_i}};

   spi_rr_pick #(
      .NUM_REQ (NUM_REQ),
      .IW      (IW)
   ) u_pick (
      .eligible (eligible),
      .last     (last),
      .valid    (pick_valid),
      .winner   (pick_idx)
   );

   // A timed-out master stays masked until it lets go of req for a cycle.
   always_comb begin
      mask_next = mask & req_i;
      if (state == ST_GRANT && owner_req && to_hit)
         mask_next[owner_o] = 1'b1;
   end

   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         state      <= ST_IDLE;
         gnt_o      <= '0;
         owner_o    <= '0;
         last       <= IW'(NUM_REQ - 1);
         mask       <= '0;
         tcnt       <= '0;
         gcnt       <= '0;
         timeout_o  <= 1'b0;
         spi_cs_o   <= SPI_CS_IDLE;
         spi_clk_o  <= CPOL;
         spi_mosi_o <= SPI_MOSI_IDLE;
      end else begin
         timeout_o <= 1'b0;
         mask      <= mask_next;
         case (state)
            ST_IDLE: begin
               if (pick_valid) begin
                  gnt_o   <= NUM_REQ'(1) << pick_idx;
                  owner_o <= pick_idx;
                  last    <= pick_idx;
                  tcnt    <= '0;
                  state   <= ST_GRANT;
               end
            end
            ST_GRANT: begin
               if (!owner_req || to_hit) begin
                  // Release forces the bus idle even if the master still holds cs low.
                  gnt_o      <= '0;
                  spi_cs_o   <= SPI_CS_IDLE;
                  spi_clk_o  <= CPOL;
                  spi_mosi_o <= SPI_MOSI_IDLE;
                  gcnt       <= '0;
                  timeout_o  <= owner_req;
                  state      <= ST_DRAIN;
               end else begin
                  spi_cs_o   <= m_cs_i[owner_o];
                  spi_clk_o  <= m_clk_i[owner_o];
                  spi_mosi_o <= m_mosi_i[owner_o];
                  tcnt       <= tcnt + 1'b1;
               end
            end
            ST_DRAIN: begin
               if (gcnt == GW'(GAP_CYCLES))
                  state <= ST_IDLE;
               else
                  gcnt <= gcnt + 1'b1;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule
